// File: rtl/ir_loader_pkg.sv
// Shared types and constants for the instruction-memory program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ir_loader_pkg;

    // Loader FSM states.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_WORD,
        ST_WRITE,
        ST_DONE,
        ST_ERR
    } state_t;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = 16;
    localparam int BIDX_W         = $clog2(BYTES_PER_WORD);

    // Minimum number of cycles from the start edge to the edge that enters DONE
    // for an n-word program: one cycle per header byte, then per word one cycle
    // per byte plus the write cycle.
    function automatic int load_cycles(input int n_words);
        return HDR_BYTES + (BYTES_PER_WORD + 1) * n_words;
    endfunction

endpackage

// File: rtl/ir_word_assembler.sv
// Packs a little-endian byte stream into 32-bit words (first byte -> bits 7:0).
// Latency: combinational word_o/word_full_o for the byte being accepted; state updates next edge.
// Backpressure: none of its own; the caller only asserts byte_vld_i on an accepted transfer.
//
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   clear_i        restart at byte 0 with an all-zero word
//   byte_vld_i     a byte is being accepted this cycle
//   byte_dat_i     the byte
//   word_o         word including the byte being accepted this cycle
//   word_full_o    the byte being accepted completes the word
module ir_word_assembler
    import ir_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic [31:0] word_o,
    output logic        word_full_o
);

    logic [BIDX_W-1:0] bidx_q, bidx_d;
    logic [31:0]       word_q, word_d;

    // The incoming byte is placed in its lane combinationally so the caller can
    // capture the complete word on the same edge that accepts the last byte.
    always_comb begin
        word_d = word_q;
        word_d[{bidx_q, 3'b000} +: 8] = byte_dat_i;
        bidx_d = bidx_q + BIDX_W'(1);
    end

    assign word_o      = word_d;
    assign word_full_o = byte_vld_i && (bidx_q == BIDX_W'(BYTES_PER_WORD - 1));

    // The byte index wraps to 0 after the last lane, ready for the next word.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bidx_q <= '0;
            word_q <= '0;
        end else if (clear_i) begin
            bidx_q <= '0;
            word_q <= '0;
        end else if (byte_vld_i) begin
            bidx_q <= bidx_d;
            word_q <= word_d;
        end
    end

endmodule

// File: rtl/ir_mem_loader.sv
// Loads a program into instruction memory from a byte stream: 16-bit LE word count, then LE words.
// Latency: write strobe the cycle after a word's 4th byte; DONE 2 + 5N cycles after start at best.
// Backpressure: byte_ready low outside header/word collection (including the write cycle); gaps stall.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start                     one-cycle load request (honoured in IDLE/DONE/ERR)
//   byte_valid/byte_data      host byte stream, transfer when byte_valid && byte_ready
//   byte_ready                loader accepts a byte this cycle
//   wr_en/wr_addr/wr_data     instruction memory write port (one-cycle strobe)
//   cpu_hold                  stall the core while a load is in progress or has failed
//   done/error                result of the last load (levels)
module ir_mem_loader
    import ir_loader_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              cpu_hold,
    output logic              done,
    output logic              error
);

    // One extra bit so the index can represent DEPTH after the final write.
    localparam int IDX_W = ADDR_W + 1;

    state_t             state_q;
    logic [COUNT_W-1:0] count_q;
    logic [IDX_W-1:0]   widx_q;
    logic               byte_ready_q;
    logic               wr_en_q;
    logic [ADDR_W-1:0]  wr_addr_q;
    logic [31:0]        wr_data_q;
    logic               cpu_hold_q;
    logic               done_q;
    logic               error_q;

    logic               accept;
    logic               start_ok;
    logic [COUNT_W-1:0] hdr_count;
    logic               last_word;
    logic               asm_vld;
    logic [31:0]        asm_word;
    logic               asm_full;

    assign accept    = byte_valid && byte_ready_q;
    assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE || state_q == ST_ERR);
    // Full count as it stands when the high header byte is being accepted.
    assign hdr_count = {byte_data, count_q[7:0]};
    assign last_word = (COUNT_W'(widx_q) + COUNT_W'(1)) == count_q;
    assign asm_vld   = accept && (state_q == ST_WORD);

    ir_word_assembler u_asm (
        .clk         (clk),
        .rst         (rst),
        .clear_i     (start_ok),
        .byte_vld_i  (asm_vld),
        .byte_dat_i  (byte_data),
        .word_o      (asm_word),
        .word_full_o (asm_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            widx_q       <= '0;
            byte_ready_q <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cpu_hold_q   <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_q      <= ST_HDR0;
                        widx_q       <= '0;
                        byte_ready_q <= 1'b1;
                        cpu_hold_q   <= 1'b1;
                        done_q       <= 1'b0;
                        error_q      <= 1'b0;
                    end
                end
                ST_HDR0: begin
                    if (accept) begin
                        count_q[7:0] <= byte_data;
                        state_q      <= ST_HDR1;
                    end
                end
                ST_HDR1: begin
                    if (accept) begin
                        count_q[15:8] <= byte_data;
                        if (hdr_count == '0) begin
                            state_q      <= ST_DONE;
                            byte_ready_q <= 1'b0;
                            cpu_hold_q   <= 1'b0;
                            done_q       <= 1'b1;
                        end else if (hdr_count > COUNT_W'(DEPTH)) begin
                            // Program would not fit: keep the core held off.
                            state_q      <= ST_ERR;
                            byte_ready_q <= 1'b0;
                            error_q      <= 1'b1;
                        end else begin
                            state_q <= ST_WORD;
                        end
                    end
                end
                ST_WORD: begin
                    if (asm_full) begin
                        state_q      <= ST_WRITE;
                        byte_ready_q <= 1'b0;
                        wr_en_q      <= 1'b1;
                        wr_addr_q    <= widx_q[ADDR_W-1:0];
                        wr_data_q    <= asm_word;
                    end
                end
                ST_WRITE: begin
                    widx_q <= widx_q + IDX_W'(1);
                    if (last_word) begin
                        state_q    <= ST_DONE;
                        cpu_hold_q <= 1'b0;
                        done_q     <= 1'b1;
                    end else begin
                        state_q      <= ST_WORD;
                        byte_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign byte_ready = byte_ready_q;
    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign cpu_hold   = cpu_hold_q;
    assign done       = done_q;
    assign error      = error_q;

endmodule

// File: tb/tb_ir_mem_loader.sv
// Scoreboard bench for ir_mem_loader: stimulus pushes expected writes, a monitor pops on wr_en.
module tb_ir_mem_loader;
    import ir_loader_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_ready;
    logic        wr_en;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        cpu_hold;
    logic        done;
    logic        error;

    ir_mem_loader #(.DEPTH(1024), .ADDR_W(10)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [9:0]  addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          t_start = 0;
    logic        prev_wr_en = 1'b0;
    logic [31:0] prog [10];
    logic [7:0]  n2_bytes [10];

    always @(posedge clk) cyc++;

    // Monitor: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            wr_t e;
            checks++;
            if (byte_ready !== 1'b0) begin
                errors++;
                $display("FAIL ready_in_write: byte_ready=%0b, required 0", byte_ready);
            end
            checks++;
            if (prev_wr_en) begin
                errors++;
                $display("FAIL wr_pulse: wr_en high two cycles in a row at addr %0d", wr_addr);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: addr=%0d data=%h, required no write", wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                if (wr_addr !== e.addr || wr_data !== e.data) begin
                    errors++;
                    $display("FAIL write: addr=%0d data=%h, required addr=%0d data=%h",
                             wr_addr, wr_data, e.addr, e.data);
                end
            end
        end
        prev_wr_en = wr_en;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_byte_ready"}, {31'd0, byte_ready}, 32'd0);
        chk({tag, "_wr_en"},      {31'd0, wr_en},      32'd0);
        chk({tag, "_wr_addr"},    {22'd0, wr_addr},    32'd0);
        chk({tag, "_wr_data"},    wr_data,             32'd0);
        chk({tag, "_cpu_hold"},   {31'd0, cpu_hold},   32'd0);
        chk({tag, "_done"},       {31'd0, done},       32'd0);
        chk({tag, "_error"},      {31'd0, error},      32'd0);
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        byte_valid = 1'b0;
        repeat (gap) @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        n = 0;
        while (!byte_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            checks++;
            errors++;
            $display("FAIL byte_timeout: byte %h never accepted, required acceptance", b);
            byte_valid = 1'b0;
            return;
        end
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t_start = cyc;
        chk("start_cpu_hold",   {31'd0, cpu_hold},   32'd1);
        chk("start_byte_ready", {31'd0, byte_ready}, 32'd1);
        chk("start_done",       {31'd0, done},       32'd0);
        chk("start_error",      {31'd0, error},      32'd0);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(name, {31'd0, done}, 32'd1);
    endtask

    // Full load of the first n entries of prog; glitch_at pulses start before that stream byte.
    task automatic load(input int n, input bit gaps, input int glitch_at);
        logic [15:0] cnt;
        cnt = 16'(n);
        do_start();
        send_byte(cnt[7:0],  gaps ? int'($urandom_range(0, 3)) : 0);
        send_byte(cnt[15:8], gaps ? int'($urandom_range(0, 3)) : 0);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (k * 4 + j == glitch_at) begin
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
                if (j == 3) exp_q.push_back(wr_t'{k[9:0], prog[k]});
                send_byte(prog[k][8*j +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
            end
        end
        wait_done("load_done");
        chk("load_cpu_hold", {31'd0, cpu_hold}, 32'd0);
        chk("load_error",    {31'd0, error},    32'd0);
        chk("load_q_empty",  exp_q.size(),      32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        prog[0] = 32'h00708333; prog[1] = 32'hFE719FE3;
        prog[2] = 32'h00200113; prog[3] = 32'h002081B3;
        prog[4] = 32'h40110233; prog[5] = 32'hFE000EE3;
        prog[6] = 32'h12345678; prog[7] = 32'hDEADBEEF;
        prog[8] = 32'h00000000; prog[9] = 32'hFFFFFFFF;
        n2_bytes = '{8'h02, 8'h00, 8'h33, 8'h83, 8'h70, 8'h00, 8'hE3, 8'h9F, 8'h71, 8'hFE};

        // Reset state.
        #2;
        chk_reset_vals("reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk_reset_vals("idle");

        // Two-word load, gap-free, spec byte stream.
        do_start();
        exp_q.push_back(wr_t'{10'd0, 32'h00708333});
        exp_q.push_back(wr_t'{10'd1, 32'hFE719FE3});
        for (int i = 0; i < 10; i++) send_byte(n2_bytes[i], 0);
        chk("n2_done_during_write", {31'd0, done}, 32'd0);
        chk("n2_hold_during_write", {31'd0, cpu_hold}, 32'd1);
        wait_done("n2_done");
        chk("n2_load_time", cyc - t_start, load_cycles(2));
        chk("n2_cpu_hold",  {31'd0, cpu_hold}, 32'd0);
        chk("n2_q_empty",   exp_q.size(), 32'd0);

        // Zero-word load.
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("n0_done",       {31'd0, done},     32'd1);
        chk("n0_load_time",  cyc - t_start,     load_cycles(0));
        chk("n0_cpu_hold",   {31'd0, cpu_hold}, 32'd0);
        chk("n0_byte_ready", {31'd0, byte_ready}, 32'd0);

        // Oversized count aborts.
        do_start();
        send_byte(8'h01, 0);
        send_byte(8'h04, 0);
        chk("err_error",      {31'd0, error},      32'd1);
        chk("err_cpu_hold",   {31'd0, cpu_hold},   32'd1);
        chk("err_done",       {31'd0, done},       32'd0);
        chk("err_byte_ready", {31'd0, byte_ready}, 32'd0);
        repeat (3) @(negedge clk);
        chk("err_sticky",     {31'd0, error},      32'd1);
        do_start();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        chk("err_recover_done", {31'd0, done}, 32'd1);

        // Random gaps: same writes as the gap-free load.
        load(2, 1'b1, -1);
        load(4, 1'b1, -1);

        // start during WORD is ignored; start in DONE reloads from address 0.
        load(3, 1'b0, 5);
        load(2, 1'b0, -1);

        // Reset between bytes 2 and 3 of word 5 of a 10-word load.
        do_start();
        send_byte(8'h0A, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 5; k++) begin
            for (int j = 0; j < 4; j++) begin
                if (j == 3) exp_q.push_back(wr_t'{k[9:0], prog[k]});
                send_byte(prog[k][8*j +: 8], 0);
            end
        end
        send_byte(prog[5][7:0], 0);
        send_byte(prog[5][15:8], 0);
        rst = 1'b1;
        #1;
        chk_reset_vals("midrst");
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_q_empty", exp_q.size(), 32'd0);
        @(negedge clk);
        load(10, 1'b0, -1);

        repeat (5) @(negedge clk);
        chk("final_q_empty", exp_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
